rsa_decrypt_engine: RTL and testbench

Receive-side RSA core that recovers plaintext m = c^d mod n from ciphertext c, private exponent d and modulus n = p*q. It consumes the primes/phi output of key generation, after d has been derived, and is the decryption counterpart to the transmit-side encryptor. It computes modular exponentiation sequentially with bit-serial interleaved modular multiplication. It runs in constant time and uses valid/ready handshakes on both sides.

---
 rtl/rsa_decrypt_engine.sv | 136 +++++++++++++
 tb/tb_rsa_decrypt_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt_engine.sv
// Constant-time RSA decryption core: m = c^d mod n by left-to-right square-and-multiply
// over all exponent bits, using a bit-serial interleaved modular multiplier.
module rsa_decrypt_engine #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ciphertext,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] plaintext,
  output logic             error,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operand set
  // CHECK | validate n >= 2 and c < n, seed result
  // SQR   | result = result*result mod n, one multiplier bit per cycle
  // MUL   | t = result*c mod n (always run), keep t only if d[i]
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, DONE} state_t;

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP_BIT = IW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] c_reg, d_reg, n_reg;
  logic [WIDTH-1:0] result, acc;
  logic [IW-1:0]    bit_i, bit_j;

  logic             bad_operands;
  logic [WIDTH-1:0] mul_b, addend, acc2, acc_next;
  logic [WIDTH:0]   n_ext, acc2_raw, acc3_raw;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign bad_operands = (n_reg < WIDTH'(2)) || (c_reg >= n_reg);

  // One step of the interleaved multiplier: acc = 2*acc + b[j]*a, kept below n.
  always_comb begin
    mul_b    = (state == SQR) ? result : c_reg;
    addend   = mul_b[bit_j] ? result : '0;
    n_ext    = {1'b0, n_reg};
    acc2_raw = {acc, 1'b0};
    acc2     = (acc2_raw >= n_ext) ? WIDTH'(acc2_raw - n_ext) : WIDTH'(acc2_raw);
    acc3_raw = {1'b0, acc2} + {1'b0, addend};
    acc_next = (acc3_raw >= n_ext) ? WIDTH'(acc3_raw - n_ext) : WIDTH'(acc3_raw);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CHECK;
      CHECK:   state_next = bad_operands ? DONE : SQR;
      SQR:     if (bit_j == '0) state_next = MUL;
      MUL:     if (bit_j == '0) state_next = (bit_i == '0) ? DONE : SQR;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      n_reg     <= '0;
      result    <= '0;
      acc       <= '0;
      bit_i     <= '0;
      bit_j     <= '0;
      plaintext <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_reg <= ciphertext;
            d_reg <= exponent;
            n_reg <= modulus;
          end
        end
        CHECK: begin
          if (bad_operands) begin
            error     <= 1'b1;
            plaintext <= '0;
          end else begin
            result <= WIDTH'(1);
            acc    <= '0;
            bit_i  <= TOP_BIT;
            bit_j  <= TOP_BIT;
          end
        end
        SQR: begin
          if (bit_j == '0) begin
            result <= acc_next;
            acc    <= '0;
            bit_j  <= TOP_BIT;
          end else begin
            acc   <= acc_next;
            bit_j <= bit_j - 1'b1;
          end
        end
        MUL: begin
          if (bit_j == '0) begin
            if (d_reg[bit_i]) result <= acc_next;
            acc   <= '0;
            bit_j <= TOP_BIT;
            if (bit_i == '0) begin
              plaintext <= d_reg[bit_i] ? acc_next : result;
              error     <= 1'b0;
            end else begin
              bit_i <= bit_i - 1'b1;
            end
          end else begin
            acc   <= acc_next;
            bit_j <= bit_j - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Directed and randomized checks of rsa_decrypt_engine at WIDTH=8 and WIDTH=16,
// with a queue of expected results popped when each output appears.
module tb_rsa_decrypt_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, error8, busy8;
  logic [7:0] c8 = 0, d8 = 0, n8 = 0, pt8;
  logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0, error16, busy16;
  logic [15:0] c16 = 0, d16 = 0, n16 = 0, pt16;

  rsa_decrypt_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .ciphertext(c8), .exponent(d8), .modulus(n8), .out_valid(out_valid8),
    .out_ready(out_ready8), .plaintext(pt8), .error(error8), .busy(busy8));

  rsa_decrypt_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .ciphertext(c16), .exponent(d16), .modulus(n16), .out_valid(out_valid16),
    .out_ready(out_ready16), .plaintext(pt16), .error(error16), .busy(busy16));

  typedef struct {
    logic [15:0] pt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  localparam int LIMIT = 2000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] modexp(input logic [15:0] c, input logic [15:0] d,
                                         input logic [15:0] n);
    longint r = 1, b = longint'(c), m = longint'(n);
    for (int i = 0; i < 16; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return 16'(r);
  endfunction

  function automatic logic get_ov(input bit w16);
    return w16 ? out_valid16 : out_valid8;
  endfunction
  function automatic logic get_ir(input bit w16);
    return w16 ? in_ready16 : in_ready8;
  endfunction
  function automatic logic get_err(input bit w16);
    return w16 ? error16 : error8;
  endfunction
  function automatic logic get_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction
  function automatic logic [15:0] get_pt(input bit w16);
    return w16 ? pt16 : {8'h00, pt8};
  endfunction

  task automatic drive(input bit w16, input logic v, input logic [15:0] c,
                       input logic [15:0] d, input logic [15:0] n);
    if (w16) begin
      in_valid16 = v; c16 = c; d16 = d; n16 = n;
    end else begin
      in_valid8 = v; c8 = c[7:0]; d8 = d[7:0]; n8 = n[7:0];
    end
  endtask

  task automatic set_oready(input bit w16, input logic r);
    if (w16) out_ready16 = r;
    else out_ready8 = r;
  endtask

  // One transaction: accept, wait for out_valid, check latency and scoreboard,
  // optionally stall out_ready for `hold` cycles, then consume.
  task automatic run(input bit w16, input logic [15:0] c, input logic [15:0] d,
                     input logic [15:0] n, input logic [15:0] exp_pt, input logic exp_err,
                     input int exp_lat, input int hold, input bit junk);
    int   lat;
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", get_ir(w16), 1);
    drive(w16, 1'b1, c, d, n);
    sb.push_back('{pt: exp_pt, err: exp_err});
    @(negedge clk);
    lat = 1;
    if (junk) drive(w16, 1'b1, ~c, ~d, ~n);
    else drive(w16, 1'b0, 16'h0, 16'h0, 16'h0);
    check("busy_running", get_busy(w16), 1);
    check("in_ready_running", get_ir(w16), 0);
    while (!get_ov(w16) && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    drive(w16, 1'b0, 16'h0, 16'h0, 16'h0);
    check("latency", lat, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("plaintext", get_pt(w16), e.pt);
      check("error", get_err(w16), e.err);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_out_valid", get_ov(w16), 1);
      check("hold_plaintext", get_pt(w16), exp_pt);
      check("hold_error", get_err(w16), exp_err);
      check("hold_in_ready", get_ir(w16), 0);
    end
    set_oready(w16, 1'b1);
    @(negedge clk);
    set_oready(w16, 1'b0);
    check("out_valid_after_consume", get_ov(w16), 0);
    check("in_ready_after_consume", get_ir(w16), 1);
    check("error_after_consume", get_err(w16), 0);
    check("plaintext_kept", get_pt(w16), exp_pt);
  endtask

  initial begin
    logic [15:0] rn, rc, rd;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_plaintext", pt8, 0);
    check("rst_error", error8, 0);
    check("rst_busy", busy8, 0);
    reset = 1'b0;

    run(0, 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, 130, 0, 0);
    run(1, 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 514, 0, 1);
    run(1, 16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, 514, 0, 0);
    run(0, 16'd0, 16'd5, 16'd1, 16'd0, 1'b1, 2, 0, 0);
    run(0, 16'd0, 16'd5, 16'd0, 16'd0, 1'b1, 2, 0, 0);
    run(0, 16'd40, 16'd7, 16'd33, 16'd0, 1'b1, 2, 0, 0);
    run(0, 16'd33, 16'd7, 16'd33, 16'd0, 1'b1, 2, 0, 0);
    run(0, 16'd5, 16'd0, 16'd33, 16'd1, 1'b0, 130, 0, 0);
    run(0, 16'd254, 16'd255, 16'd255, 16'd254, 1'b0, 130, 0, 0);
    run(0, 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, 130, 20, 0);
    run(0, 16'd40, 16'd7, 16'd33, 16'd0, 1'b1, 2, 20, 0);

    // Abort a run mid-way; the asynchronous reset must clear outputs without a clock edge.
    @(negedge clk);
    drive(0, 1'b1, 16'd31, 16'd7, 16'd33);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (49) @(negedge clk);
    check("midrun_busy", busy8, 1);
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready8, 1);
    check("abort_out_valid", out_valid8, 0);
    check("abort_plaintext", pt8, 0);
    check("abort_error", error8, 0);
    check("abort_busy", busy8, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, 130, 0, 0);

    for (int t = 0; t < 12; t++) begin
      rn = 16'($urandom_range(2, 65535));
      rc = 16'($urandom_range(0, int'(rn) - 1));
      rd = 16'($urandom);
      run(1, rc, rd, rn, modexp(rc, rd, rn), 1'b0, 514, 0, 0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
